// File: rtl/bcp_walker.sv
// bcp_walker: walks a linked list of clause nodes, classifying each
// against the current assignment and emitting unit implications.
`ifndef CLQ_DEPTH
`define CLQ_DEPTH 16
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 16
`endif

module bcp_walker #(
   parameter int DEPTH = `CLQ_DEPTH,
   parameter int NUM_LIT = `LIT_IDX_MAX,
   parameter int K = 3,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = $clog2(NUM_LIT) + 1,
   localparam int NW = K * LW + PW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PW-1:0]      init_ptr,
   input  logic               init_ptr_valid,
   output logic [PW-1:0]      cnf_idx,
   input  logic [NW-1:0]      node_in,
   input  logic [NUM_LIT-1:0] asg_set,
   input  logic [NUM_LIT-1:0] asg_val,
   output logic [LW-1:0]      imp_lit,
   output logic               imp_valid,
   input  logic               imp_ready,
   output logic               busy,
   output logic               done,
   output logic               conflict,
   output logic               loop_err
);

   localparam int CW = PW + 1;
   localparam int IW = LW - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WALK,
      S_EMIT,
      S_CONFL,
      S_DONE,
      S_ERR
   } state_t;

   state_t state, state_n;

   logic [PW-1:0] ptr, ptr_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [LW-1:0] lit_q, lit_n;
   logic [PW-1:0] sv_ptr, sv_ptr_n;
   logic          sv_null, sv_null_n;

   logic [K-1:0]  is_true;
   logic [K-1:0]  is_unas;
   logic [LW-1:0] unit_lit;
   logic [PW-1:0] nd_ptr;
   logic          nd_null;
   logic          cls_confl;
   logic          cls_unit;

   assign nd_null = node_in[0];
   assign nd_ptr  = node_in[PW:1];

   // Per-slot literal status; out-of-range magnitudes are ignored like empty slots
   for (genvar g = 0; g < K; g++) begin : g_lit
      logic [LW-1:0] lit;
      logic [LW-1:0] mag;
      logic [IW-1:0] idx;
      logic          ok;
      logic          set_b;
      logic          val_b;

      assign lit   = node_in[PW+1+g*LW +: LW];
      assign mag   = lit[LW-1] ? -lit : lit;
      assign ok    = (lit != '0) && (mag < LW'(NUM_LIT));
      assign idx   = mag[IW-1:0];
      assign set_b = asg_set[idx];
      assign val_b = asg_val[idx];

      assign is_true[g] = ok && set_b && (val_b == ~lit[LW-1]);
      assign is_unas[g] = ok && !set_b;
   end

   assign cls_confl = (is_true == '0) && (is_unas == '0);
   assign cls_unit  = (is_true == '0) && $onehot(is_unas);

   always_comb begin
      unit_lit = '0;
      for (int i = K - 1; i >= 0; i--) begin
         if (is_unas[i]) begin
            unit_lit = node_in[PW+1+i*LW +: LW];
         end
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      lit_n     = lit_q;
      sv_ptr_n  = sv_ptr;
      sv_null_n = sv_null;
      unique case (state)
         S_IDLE: begin
            if (init_ptr_valid) begin
               ptr_n   = init_ptr;
               cnt_n   = '0;
               state_n = S_WALK;
            end
         end
         S_WALK: begin
            // A full budget of visits means the list must be cyclic
            if (cnt == CW'(DEPTH)) begin
               state_n = S_ERR;
            end else begin
               cnt_n = cnt + CW'(1);
               if (cls_confl) begin
                  state_n = S_CONFL;
               end else if (cls_unit) begin
                  lit_n     = unit_lit;
                  sv_ptr_n  = nd_ptr;
                  sv_null_n = nd_null;
                  state_n   = S_EMIT;
               end else if (nd_null) begin
                  state_n = S_DONE;
               end else begin
                  ptr_n = nd_ptr;
               end
            end
         end
         S_EMIT: begin
            if (imp_ready) begin
               if (sv_null) begin
                  state_n = S_DONE;
               end else begin
                  ptr_n   = sv_ptr;
                  state_n = S_WALK;
               end
            end
         end
         S_CONFL, S_DONE, S_ERR: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= '0;
         cnt     <= '0;
         lit_q   <= '0;
         sv_ptr  <= '0;
         sv_null <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         lit_q   <= lit_n;
         sv_ptr  <= sv_ptr_n;
         sv_null <= sv_null_n;
      end
   end

   assign cnf_idx   = ptr;
   assign imp_lit   = lit_q;
   assign imp_valid = (state == S_EMIT);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign conflict  = (state == S_CONFL);
   assign loop_err  = (state == S_ERR);

endmodule

// File: tb/tb_bcp_walker.sv
// tb_bcp_walker: random clause lists checked against a list-walk model,
// plus directed unit, chain, conflict, stall, loop and reset cases.
module tb_bcp_walker;

   localparam int DEPTH = 16;
   localparam int NUM_LIT = 16;
   localparam int K = 3;
   localparam int PW = 4;
   localparam int LW = 5;
   localparam int NW = K * LW + PW + 1;

   logic               clk;
   logic               rst_n;
   logic [PW-1:0]      init_ptr;
   logic               init_ptr_valid;
   logic [PW-1:0]      cnf_idx;
   logic [NW-1:0]      node_in;
   logic [NUM_LIT-1:0] aset;
   logic [NUM_LIT-1:0] aval;
   logic [LW-1:0]      imp_lit;
   logic               imp_valid;
   logic               imp_ready;
   logic               busy;
   logic               done;
   logic               conflict;
   logic               loop_err;

   int m_lit [DEPTH][K];
   int m_nxt [DEPTH];
   bit m_nul [DEPTH];
   int stall_tbl [16];

   int exp_addr[$];
   int exp_lit[$];
   int got_addr[$];
   int got_lit[$];

   int ntests;
   int nfail;

   bcp_walker #(
      .DEPTH(DEPTH),
      .NUM_LIT(NUM_LIT),
      .K(K)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .init_ptr(init_ptr),
      .init_ptr_valid(init_ptr_valid),
      .cnf_idx(cnf_idx),
      .node_in(node_in),
      .asg_set(aset),
      .asg_val(aval),
      .imp_lit(imp_lit),
      .imp_valid(imp_valid),
      .imp_ready(imp_ready),
      .busy(busy),
      .done(done),
      .conflict(conflict),
      .loop_err(loop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clause memory answers the read address in the same cycle
   always_comb begin
      node_in = '0;
      for (int i = 0; i < K; i++) begin
         node_in[PW+1+i*LW +: LW] = LW'(m_lit[cnf_idx][i]);
      end
      node_in[PW:1] = PW'(m_nxt[cnf_idx]);
      node_in[0] = m_nul[cnf_idx];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < K; j++) m_lit[i][j] = 0;
         m_nxt[i] = 0;
         m_nul[i] = 1'b1;
      end
      for (int i = 0; i < 16; i++) stall_tbl[i] = 0;
      aset = '0;
      aval = '0;
   endtask

   // Reference: follow the list, classify each clause, record
   // every presented address, implied literal and the outcome.
   task automatic model(input int head, output int outc);
      int p, visits, tru, unas, ul, v, l;
      exp_addr.delete();
      exp_lit.delete();
      p = head;
      visits = 0;
      outc = -1;
      while (outc < 0) begin
         exp_addr.push_back(p);
         if (visits == DEPTH) begin
            outc = 2;
         end else begin
            visits++;
            tru = 0;
            unas = 0;
            ul = 0;
            for (int j = 0; j < K; j++) begin
               l = m_lit[p][j];
               if (l != 0) begin
                  v = (l < 0) ? -l : l;
                  if (aset[v]) begin
                     if (aval[v] == (l > 0)) tru = 1;
                  end else begin
                     if (unas == 0) ul = l;
                     unas++;
                  end
               end
            end
            if (tru == 0 && unas == 0) begin
               outc = 1;
            end else begin
               if (tru == 0 && unas == 1) exp_lit.push_back(ul & 31);
               if (m_nul[p]) outc = 0;
               else p = m_nxt[p];
            end
         end
      end
   endtask

   task automatic run_walk(input int head, input string nm);
      int outc, got_out, k, left, busy_cyc, exp_busy, n;
      bit prev, fin;
      logic [LW-1:0] held;
      got_addr.delete();
      got_lit.delete();
      model(head, outc);
      @(negedge clk);
      init_ptr = PW'(head);
      init_ptr_valid = 1'b1;
      @(negedge clk);
      init_ptr_valid = 1'b0;
      k = 0;
      prev = 0;
      fin = 0;
      busy_cyc = 0;
      got_out = -1;
      left = 0;
      held = '0;
      for (int c = 0; c < 600 && !fin; c++) begin
         if (busy) busy_cyc++;
         n = int'(done) + int'(conflict) + int'(loop_err);
         if (n != 0) begin
            fin = 1;
            got_out = (n > 1) ? 9 : done ? 0 : conflict ? 1 : 2;
            imp_ready = 1'b0;
         end else if (imp_valid) begin
            if (!prev) begin
               got_lit.push_back(int'(imp_lit));
               held = imp_lit;
               left = stall_tbl[k % 16];
               k++;
            end else begin
               check({nm, "_lit_hold"}, 32'(imp_lit), 32'(held));
            end
            prev = 1;
            imp_ready = (left == 0);
            if (left > 0) left--;
         end else begin
            prev = 0;
            imp_ready = 1'b0;
            if (busy) got_addr.push_back(int'(cnf_idx));
         end
         if (!fin) @(negedge clk);
      end
      if (!fin) check({nm, "_timeout"}, 0, 1);
      check({nm, "_outcome"}, got_out, outc);
      check({nm, "_n_addr"}, got_addr.size(), exp_addr.size());
      for (int j = 0; j < exp_addr.size() && j < got_addr.size(); j++)
         check({nm, "_addr"}, got_addr[j], exp_addr[j]);
      check({nm, "_n_lit"}, got_lit.size(), exp_lit.size());
      for (int j = 0; j < exp_lit.size() && j < got_lit.size(); j++)
         check({nm, "_lit"}, got_lit[j], exp_lit[j]);
      exp_busy = exp_addr.size() + 1;
      for (int j = 0; j < exp_lit.size(); j++)
         exp_busy += stall_tbl[j % 16] + 1;
      check({nm, "_busy_cyc"}, busy_cyc, exp_busy);
      @(negedge clk);
      check({nm, "_idle"}, {busy, done, conflict, loop_err, imp_valid}, 0);
   endtask

   initial begin
      ntests = 0;
      nfail = 0;
      rst_n = 1'b0;
      init_ptr = '0;
      init_ptr_valid = 1'b0;
      imp_ready = 1'b0;
      clear_mem();

      repeat (2) @(negedge clk);
      check("rst_cnf_idx", 32'(cnf_idx), 0);
      check("rst_imp_lit", 32'(imp_lit), 0);
      check("rst_imp_valid", 32'(imp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pulses", {done, conflict, loop_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_start", 32'(busy), 0);

      // Single unit clause {+1,-2,+3}: x1=F, x2=T, x3 unset
      clear_mem();
      m_lit[2][0] = 1;
      m_lit[2][1] = -2;
      m_lit[2][2] = 3;
      aset[1] = 1'b1;
      aval[1] = 1'b0;
      aset[2] = 1'b1;
      aval[2] = 1'b1;
      run_walk(2, "unit");

      // Chain 0 -> 5 -> 9, every clause satisfied by x1
      clear_mem();
      m_lit[0][0] = 1;
      m_nul[0] = 1'b0;
      m_nxt[0] = 5;
      m_lit[5][0] = 1;
      m_nul[5] = 1'b0;
      m_nxt[5] = 9;
      m_lit[9][0] = 1;
      aset[1] = 1'b1;
      aval[1] = 1'b1;
      run_walk(0, "chain");

      // All-false clause stops the walk before node 7
      clear_mem();
      m_lit[6][0] = 1;
      m_lit[6][1] = 2;
      m_nul[6] = 1'b0;
      m_nxt[6] = 7;
      m_lit[7][0] = 3;
      aset[1] = 1'b1;
      aset[2] = 1'b1;
      run_walk(6, "confl");

      // Unit with a 4-cycle ready stall, then resume at node 11
      clear_mem();
      m_lit[8][0] = -4;
      m_nul[8] = 1'b0;
      m_nxt[8] = 11;
      m_lit[11][0] = 5;
      aset[5] = 1'b1;
      aval[5] = 1'b1;
      stall_tbl[0] = 4;
      run_walk(8, "stall");

      // Cycle 3 -> 7 -> 3 of open clauses
      clear_mem();
      m_lit[3][0] = 1;
      m_lit[3][1] = 2;
      m_nul[3] = 1'b0;
      m_nxt[3] = 7;
      m_lit[7][0] = 1;
      m_lit[7][1] = 2;
      m_nul[7] = 1'b0;
      m_nxt[7] = 3;
      run_walk(3, "loop");

      // Reset asserted while an implication is pending
      clear_mem();
      m_lit[4][0] = 6;
      imp_ready = 1'b0;
      @(negedge clk);
      init_ptr = 4'd4;
      init_ptr_valid = 1'b1;
      @(negedge clk);
      init_ptr_valid = 1'b0;
      for (int c = 0; c < 5 && !imp_valid; c++) @(negedge clk);
      check("rst_emit_reach", 32'(imp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_emit_valid", 32'(imp_valid), 0);
      check("rst_emit_busy", 32'(busy), 0);
      check("rst_emit_idx", 32'(cnf_idx), 0);
      check("rst_emit_lit", 32'(imp_lit), 0);
      repeat (2) begin
         @(negedge clk);
         check("rst_hold_quiet", {busy, done, conflict, loop_err}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_post_idle", {busy, done, conflict, loop_err}, 0);
      run_walk(4, "post_rst");

      // Random lists, assignments and ready stalls
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < K; j++) begin
               if ($urandom_range(0, 3) == 0) begin
                  m_lit[i][j] = 0;
               end else begin
                  m_lit[i][j] = int'($urandom_range(1, 15));
                  if ($urandom_range(0, 1) == 1) m_lit[i][j] = -m_lit[i][j];
               end
            end
            m_nxt[i] = int'($urandom_range(0, DEPTH - 1));
            m_nul[i] = ($urandom_range(0, 3) == 0);
         end
         for (int i = 0; i < 16; i++) stall_tbl[i] = int'($urandom_range(0, 3));
         aset = NUM_LIT'($urandom);
         aval = NUM_LIT'($urandom);
         run_walk(int'($urandom_range(0, DEPTH - 1)), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/bcp_walker.md
BCP_WALKER -- requirements
Module: bcp_walker

Interface
REQ-001 SHALL have parameter DEPTH, default 16 (=`CLQ_DEPTH), clause-queue entries; PW = $clog2(DEPTH).
REQ-002 SHALL have parameter NUM_LIT, default `LIT_IDX_MAX, variable index space; LW = $clog2(NUM_LIT)+1.
REQ-003 SHALL have parameter K, default 3, literals per clause node.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 init_ptr  in  PW  head clause pointer from clause queue.
REQ-007 init_ptr_valid  in  1  head pointer valid; sampled only in IDLE.
REQ-008 cnf_idx  out  PW  clause-queue read address; node returns combinationally, same cycle.
REQ-009 node_in  in  K*LW+PW+1  {lit[K-1..0], next_ptr, next_null}; lit 0 = empty slot.
REQ-010 asg_set  in  NUM_LIT  per-variable assigned flag.
REQ-011 asg_val  in  NUM_LIT  per-variable value (1=true); meaningful only when asg_set.
REQ-012 imp_lit  out  LW  implied literal.
REQ-013 imp_valid / imp_ready  out/in  1  implied-literal handshake.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse: walk finished without conflict.
REQ-016 conflict  out  1  one-cycle pulse: all-false clause found.
REQ-017 loop_err  out  1  one-cycle pulse: walk exceeded DEPTH nodes.

Function
REQ-018 Literal encoding SHALL be LW-bit two's complement; MSB=1 negative; variable = magnitude (negate when MSB set); variable 0 invalid.
REQ-019 Literal status SHALL be: TRUE if asg_set[v] and asg_val[v] equals polarity-positive; FALSE if asg_set[v] and mismatch; UNASSIGNED otherwise; empty slot ignored.
REQ-020 Clause class SHALL be: SAT if any TRUE; CONFL if no TRUE and no UNASSIGNED; UNIT if no TRUE and exactly one UNASSIGNED; OPEN otherwise.
REQ-021 FSM states SHALL be IDLE, WALK, EMIT, CONFL, DONE, ERR.
REQ-022 IDLE: init_ptr_valid=1 -> latch ptr<=init_ptr, visit count<=0, go WALK next cycle; else stay.
REQ-023 WALK: cnf_idx=ptr; classify node_in that cycle; count<=count+1.
REQ-024 WALK, UNIT: register imp_lit<=unassigned literal and next fields; go EMIT.
REQ-025 WALK, CONFL: go CONFL; remaining nodes not visited.
REQ-026 WALK, SAT/OPEN: next_null=1 -> DONE; else ptr<=next_ptr, stay WALK (one node per cycle).
REQ-027 WALK: if count reaches DEPTH before a terminating decision, go ERR; takes priority over CONFL/UNIT/next.
REQ-028 EMIT: imp_valid=1, imp_lit stable until imp_valid&&imp_ready; on handshake -> DONE if saved next_null else ptr<=saved next_ptr, WALK.
REQ-029 CONFL/DONE/ERR: assert conflict/done/loop_err respectively for exactly one cycle, then IDLE.
REQ-030 init_ptr_valid SHALL be ignored while busy; no queuing.
REQ-031 cnf_idx SHALL hold last ptr outside WALK.
REQ-032 Assignment inputs SHALL be sampled only in WALK; changes during EMIT do not re-evaluate.
REQ-033 DEPTH-1 -> 0 pointers SHALL be followed unchanged; no wrap arithmetic applied.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, ptr=0, count=0, cnf_idx=0, imp_lit=0, imp_valid=0, busy=0, done=0, conflict=0, loop_err=0.
REQ-035 Reset mid-walk or mid-EMIT SHALL abort without any done/conflict pulse; first post-reset cycle is IDLE.

Verification
REQ-036 Single node ptr 2: lits {+1,-2,+3}, x1=F,x2=T,x3 unset, next_null=1 -> imp_lit=+3 one cycle after WALK; ready held -> done pulse after handshake.
REQ-037 Chain 0->5->9 all SAT -> cnf_idx 0,5,9 on consecutive cycles, done 1 cycle after node 9, no imp_valid.
REQ-038 Node {+1,+2,0}, x1=F,x2=F -> conflict pulse, next node never addressed, IDLE after.
REQ-039 imp_ready low 4 cycles in EMIT -> imp_valid and imp_lit stable 4 cycles; walk resumes at saved next_ptr after handshake.
REQ-040 Cyclic list 3->7->3 (DEPTH=16), all OPEN -> loop_err after 16 visits, no done.
REQ-041 rst_n low during EMIT -> imp_valid 0 immediately (asynchronous), busy 0, no pulses; new init_ptr accepted after release.
